ram_sync: RTL and testbench
===========================

Name: ram_sync

Overview:
- Parametrised, clocked successor to the processor's 4-bit asynchronous data RAM.
- Single-port synchronous memory with separate write and read data buses, so there is no tri-state bus.
- Registered read carries a valid flag. An optional hardware clear sweep runs after reset.
- Sits between the processor's operand/program-byte address path and its accumulator/data bus.

Parameters:
- DATA_W, 4, width of one memory word in bits.
- ADDR_W, 12, address width in bits; depth = 2**ADDR_W words.
- CLEAR_ON_RESET, 1, when 1 every word is zeroed by a sweep after reset; when 0 the block is ready immediately and contents stay undefined.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  chip select; a request is accepted only when cs=1 and busy=0.
- we  input  1  1 = write, 0 = read; sampled with cs.
- addr  input  ADDR_W  word address; the processor drives {oprnd, program_byte}.
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  registered read data.
- rvalid  output  1  one-cycle pulse; rdata holds a fresh read result.
- busy  output  1  high while the clear sweep runs; requests are ignored.

Behaviour:
- Reset (reset=1 at a rising edge):
  - rdata=0, rvalid=0, sweep counter=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else READY.
  - busy mirrors the state: 1 in CLEAR, 0 in READY.
  - Reset during a sweep restarts the sweep from address 0.
- States: CLEAR, READY. Two-state FSM, registered.
- CLEAR state:
  - Each cycle writes 0 to mem[cnt] and increments cnt.
  - When cnt = 2**ADDR_W-1 is written, the next state is READY.
  - The sweep takes exactly 2**ADDR_W cycles.
  - cs, we, addr and wdata are ignored and rvalid stays 0.
- READY state:
  - Write (cs=1, we=1): mem[addr] <= wdata at the edge. rvalid=0 next cycle. rdata is unchanged.
  - Read (cs=1, we=0): rdata <= mem[addr] and rvalid=1 in the cycle after the request. Latency is 1.
  - Idle (cs=0): rvalid=0 next cycle. rdata holds its last value.
  - Back-to-back reads are supported, one per cycle, with rvalid high continuously.
- Read-after-write: a read one cycle after a write to the same address returns the new data. No stale read is permitted.
- Writes while busy=1 are dropped. They must not corrupt the sweep or any other word.
- Address wrap: not applicable. The full addr range maps one-to-one onto the memory, with no aliasing.
- Width rule: wdata is stored unmodified. There is no sign extension or truncation inside the block.
- Synthesis: the memory array carries no reset. Only rdata, rvalid, the state and cnt are reset. The array must infer block RAM.

Decomposition:
- Shared include file ram_defs.vh holds:
  - the state encodings ST_CLEAR=1'b0 and ST_READY=1'b1;
  - the default DATA_W and ADDR_W values used by the processor top.
- One natural sub-module, ram_clear_seq. It holds the sweep counter and FSM, and outputs busy, clr_we and clr_addr.
- The memory array and read register stay in ram_sync, with a write-port mux that selects between the sweep and the user request.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_W=4 -> busy=1 for exactly 16 cycles, then 0. Reads of addresses 0..15 all return 0 with rvalid=1 one cycle after each request.
- Write 4'hA to 12'h3F2, then read 12'h3F2 on the next cycle -> rdata=4'hA with rvalid=1 one cycle after the read. A read of 12'h3F3 returns 4'h0.
- Reads of 0x000, 0x001 and 0xFFF on three consecutive cycles, preloaded with 5, 6 and 7 -> rdata=5,6,7 on three consecutive cycles with rvalid held high. rdata holds 7 after cs drops, and rvalid goes to 0.
- With ADDR_W=4, write 4'hF to address 2 while busy=1 (sweep at cnt=5) -> after busy falls, address 2 reads 0.
- Assert reset at sweep cnt=9 -> busy stays 1 and the sweep restarts at 0, taking a further 16 cycles. No early READY.
- CLEAR_ON_RESET=0 -> busy=0 in the first cycle after reset. Write then read of address 7 with 4'h3 returns 4'h3 at latency 1.

Source files
------------

// File: rtl/ram_sync_pkg.sv
// Shared definitions for the synchronous data RAM: sweep FSM encoding and the
// default geometry used by the processor top.
package ram_sync_pkg;

    typedef enum logic {
        StClear = 1'b0,
        StReady = 1'b1
    } ram_state_e;

    localparam int unsigned DefDataW = 4;
    localparam int unsigned DefAddrW = 12;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, then
// hands the memory over to the user port.
module ram_clear_seq
    import ram_sync_pkg::*;
#(
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LastAddr   = '1;
    localparam ram_state_e        ResetState = CLEAR_ON_RESET ? StClear : StReady;

    ram_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;

    // A reset mid-sweep simply restarts from address 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ResetState;
            cnt_q   <= '0;
        end else if (state_q == StClear) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastAddr) begin
                state_q <= StReady;
            end
        end
    end

    always_comb begin
        busy     = (state_q == StClear);
        clr_we   = busy;
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/ram_sync.sv
// Single-port synchronous data RAM with split read/write buses, a registered
// read carrying a valid pulse, and an optional zero sweep after reset.
module ram_sync
    import ram_sync_pkg::*;
#(
    parameter int unsigned DATA_W         = DefDataW,
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              wr_req;
    logic              rd_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem [Depth];
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    ram_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // User requests are dropped outright while the sweep owns the write port.
    always_comb begin
        wr_req = cs & we & ~busy & ~reset;
        rd_req = cs & ~we & ~busy & ~reset;
    end

    always_comb begin
        mem_we    = clr_we | wr_req;
        mem_waddr = clr_we ? clr_addr : addr;
        mem_wdata = clr_we ? '0 : wdata;
    end

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_req;
            if (rd_req) begin
                rdata_q <= mem[addr];
            end
        end
    end

    always_comb begin
        rdata  = rdata_q;
        rvalid = rvalid_q;
    end

endmodule

// File: tb/tb_ram_sync.sv
// Self-checking bench for ram_sync: three instances (small cleared, full-size
// cleared, small uncleared) against a word-level behavioural model.
module tb_ram_sync;

    localparam int N = 3;

    logic       clock;
    logic       reset_v  [N];
    logic       cs_v     [N];
    logic       we_v     [N];
    logic [11:0] addr_v  [N];
    logic [3:0] wdata_v  [N];
    logic [3:0] rdata_v  [N];
    logic       rvalid_v [N];
    logic       busy_v   [N];

    int errors = 0;
    int checks = 0;

    ram_sync #(.DATA_W(4), .ADDR_W(4), .CLEAR_ON_RESET(1'b1)) u_dut_a (
        .clock  (clock),
        .reset  (reset_v[0]),
        .cs     (cs_v[0]),
        .we     (we_v[0]),
        .addr   (addr_v[0][3:0]),
        .wdata  (wdata_v[0]),
        .rdata  (rdata_v[0]),
        .rvalid (rvalid_v[0]),
        .busy   (busy_v[0])
    );

    ram_sync #(.DATA_W(4), .ADDR_W(12), .CLEAR_ON_RESET(1'b1)) u_dut_b (
        .clock  (clock),
        .reset  (reset_v[1]),
        .cs     (cs_v[1]),
        .we     (we_v[1]),
        .addr   (addr_v[1]),
        .wdata  (wdata_v[1]),
        .rdata  (rdata_v[1]),
        .rvalid (rvalid_v[1]),
        .busy   (busy_v[1])
    );

    ram_sync #(.DATA_W(4), .ADDR_W(4), .CLEAR_ON_RESET(1'b0)) u_dut_c (
        .clock  (clock),
        .reset  (reset_v[2]),
        .cs     (cs_v[2]),
        .we     (we_v[2]),
        .addr   (addr_v[2][3:0]),
        .wdata  (wdata_v[2]),
        .rdata  (rdata_v[2]),
        .rvalid (rvalid_v[2]),
        .busy   (busy_v[2])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    function automatic int depth_of(input int i);
        return (i == 1) ? 4096 : 16;
    endfunction

    function automatic bit clear_of(input int i);
        return (i != 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Model: memory contents as plain arrays; a sweep is "remaining busy cycles"
    // whose end result (all zeros) is applied up front since nothing can observe
    // the intermediate state.
    logic [3:0] mem_m       [N][4096];
    bit         known_m     [N][4096];
    int         sweep_left  [N];
    bit         exp_rvalid  [N];
    logic [3:0] exp_rdata   [N];
    bit         rdata_known [N];
    bit         started     [N];

    always @(posedge clock) begin
        int a;
        for (int i = 0; i < N; i++) begin
            if (reset_v[i]) begin
                started[i]     = 1'b1;
                exp_rvalid[i]  = 1'b0;
                exp_rdata[i]   = 4'h0;
                rdata_known[i] = 1'b1;
                sweep_left[i]  = clear_of(i) ? depth_of(i) : 0;
                if (clear_of(i)) begin
                    for (int k = 0; k < depth_of(i); k++) begin
                        mem_m[i][k]   = 4'h0;
                        known_m[i][k] = 1'b1;
                    end
                end
            end else if (sweep_left[i] > 0) begin
                sweep_left[i] = sweep_left[i] - 1;
                exp_rvalid[i] = 1'b0;
            end else if (cs_v[i]) begin
                a = int'(addr_v[i]) % depth_of(i);
                if (we_v[i]) begin
                    mem_m[i][a]   = wdata_v[i];
                    known_m[i][a] = 1'b1;
                    exp_rvalid[i] = 1'b0;
                end else begin
                    exp_rvalid[i]  = 1'b1;
                    exp_rdata[i]   = mem_m[i][a];
                    rdata_known[i] = known_m[i][a];
                end
            end else begin
                exp_rvalid[i] = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (started[i]) begin
                check($sformatf("cmp_busy[%0d]", i), 32'(busy_v[i]), 32'(sweep_left[i] > 0));
                check($sformatf("cmp_rvalid[%0d]", i), 32'(rvalid_v[i]), 32'(exp_rvalid[i]));
                if (rdata_known[i]) begin
                    check($sformatf("cmp_rdata[%0d]", i), 32'(rdata_v[i]), 32'(exp_rdata[i]));
                end
            end
        end
    end

    function automatic logic [4:0] rv(input int i);
        return {rvalid_v[i], rdata_v[i]};
    endfunction

    task automatic op(input int i, input bit c, input bit w, input logic [11:0] a,
                      input logic [3:0] d);
        cs_v[i]    = c;
        we_v[i]    = w;
        addr_v[i]  = a;
        wdata_v[i] = d;
        @(negedge clock);
        cs_v[i] = 1'b0;
        we_v[i] = 1'b0;
    endtask

    task automatic do_reset(input int i);
        reset_v[i] = 1'b1;
        cs_v[i]    = 1'b0;
        @(negedge clock);
        reset_v[i] = 1'b0;
    endtask

    task automatic count_busy(input int i, output int n);
        n = 0;
        while (busy_v[i] && n < 5000) begin
            n++;
            @(negedge clock);
        end
    endtask

    int n;

    initial begin
        for (int i = 0; i < N; i++) begin
            reset_v[i] = 1'b1;
            cs_v[i]    = 1'b0;
            we_v[i]    = 1'b0;
            addr_v[i]  = '0;
            wdata_v[i] = '0;
        end
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < N; i++) reset_v[i] = 1'b0;

        // Small cleared instance: sweep length, cleared contents
        do_reset(0);
        count_busy(0, n);
        check("a_sweep_len", 32'(n), 32'd16);
        for (int k = 0; k < 16; k++) begin
            op(0, 1'b1, 1'b0, 12'(k), 4'h0);
            check($sformatf("a_clr_rd%0d", k), 32'(rv(0)), 32'h10);
        end

        // Write at cnt=5 during the sweep must be dropped
        do_reset(0);
        repeat (5) @(negedge clock);
        op(0, 1'b1, 1'b1, 12'h002, 4'hF);
        count_busy(0, n);
        op(0, 1'b1, 1'b0, 12'h002, 4'h0);
        check("a_busy_wr_dropped", 32'(rv(0)), 32'h10);

        // Reset at cnt=9 restarts a full sweep
        do_reset(0);
        repeat (9) @(negedge clock);
        do_reset(0);
        count_busy(0, n);
        check("a_restart_len", 32'(n), 32'd16);

        // Full-size instance
        count_busy(1, n);
        check("b_ready", 32'(busy_v[1]), 32'd0);
        op(1, 1'b1, 1'b1, 12'h3F2, 4'hA);
        op(1, 1'b1, 1'b0, 12'h3F2, 4'h0);
        check("b_raw_3f2", 32'(rv(1)), 32'h1A);
        op(1, 1'b1, 1'b0, 12'h3F3, 4'h0);
        check("b_rd_3f3", 32'(rv(1)), 32'h10);
        op(1, 1'b1, 1'b1, 12'h000, 4'h5);
        op(1, 1'b1, 1'b1, 12'h001, 4'h6);
        op(1, 1'b1, 1'b1, 12'hFFF, 4'h7);
        op(1, 1'b1, 1'b0, 12'h000, 4'h0);
        check("b_b2b_0", 32'(rv(1)), 32'h15);
        op(1, 1'b1, 1'b0, 12'h001, 4'h0);
        check("b_b2b_1", 32'(rv(1)), 32'h16);
        op(1, 1'b1, 1'b0, 12'hFFF, 4'h0);
        check("b_b2b_fff", 32'(rv(1)), 32'h17);
        op(1, 1'b0, 1'b0, 12'h000, 4'h0);
        check("b_hold", 32'(rv(1)), 32'h07);

        // Uncleared instance: ready immediately
        do_reset(2);
        check("c_busy", 32'(busy_v[2]), 32'd0);
        op(2, 1'b1, 1'b1, 12'h007, 4'h3);
        op(2, 1'b1, 1'b0, 12'h007, 4'h0);
        check("c_raw_7", 32'(rv(2)), 32'h13);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
